// File: rtl/inst_fetch_pkg.sv
// Shared constants and state encoding for the byte-serial instruction fetch unit.
// Every file of the fetch slice imports this package, so these names are defined once.
package inst_fetch_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    localparam logic [INST_W-1:0] ZERO_WORD = '0;
    localparam logic              ENABLE    = 1'b1;
    localparam logic              BRANCH    = 1'b1;
    localparam logic              NO_STOP   = 1'b0;

    // BYTEk is encoded as k so the low two bits double as the byte offset.
    typedef enum logic [2:0] {
        BYTE0 = 3'd0,
        BYTE1 = 3'd1,
        BYTE2 = 3'd2,
        BYTE3 = 3'd3,
        HOLD  = 3'd4
    } fetch_state_t;

    function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch over a byte-wide memory port: four byte reads assemble one
// little-endian word, which is held for the IF/ID register until it is consumed.
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   branch_flag_i,
    input  logic [INST_ADDR_W-1:0] branch_target_i,
    output logic                   mem_req_o,
    output logic [INST_ADDR_W-1:0] mem_addr_o,
    input  logic                   mem_ack_i,
    input  logic [7:0]             mem_rdata_i,
    output logic [INST_ADDR_W-1:0] if_pc_o,
    output logic [INST_W-1:0]      if_inst_o,
    output logic                   if_valid_o,
    output logic                   stallreq_o
);

    fetch_state_t           state;
    fetch_state_t           state_next;
    logic [INST_ADDR_W-1:0] pc;
    logic [23:0]            byte_buf;
    logic                   ack;
    logic                   consume;

    // A redirect swallows any ack in the same cycle.
    assign ack     = (mem_ack_i == ENABLE) && (branch_flag_i != BRANCH);
    assign consume = (state == HOLD) && (stall_i == NO_STOP);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BYTE0;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        if (branch_flag_i == BRANCH) begin
            state_next = BYTE0;
        end else begin
            case (state)
                BYTE0:   if (ack) state_next = BYTE1;
                BYTE1:   if (ack) state_next = BYTE2;
                BYTE2:   if (ack) state_next = BYTE3;
                BYTE3:   if (ack) state_next = HOLD;
                HOLD:    if (consume) state_next = BYTE0;
                default: state_next = BYTE0;
            endcase
        end
    end

    always_comb begin
        mem_req_o  = 1'b0;
        mem_addr_o = ZERO_WORD;
        stallreq_o = 1'b0;
        if (state != HOLD) begin
            mem_req_o  = 1'b1;
            mem_addr_o = word_align(pc) + {30'd0, state[1:0]};
        end
        if (!rst) begin
            stallreq_o = !if_valid_o;
        end
    end

    // NOTE: the byte buffer is a handful of flops, not a memory array, so it
    // takes the asynchronous reset along with the rest of the datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= ZERO_WORD;
            byte_buf   <= '0;
            if_pc_o    <= ZERO_WORD;
            if_inst_o  <= ZERO_WORD;
            if_valid_o <= 1'b0;
        end else if (branch_flag_i == BRANCH) begin
            pc         <= word_align(branch_target_i);
            byte_buf   <= '0;
            if_pc_o    <= ZERO_WORD;
            if_inst_o  <= ZERO_WORD;
            if_valid_o <= 1'b0;
        end else begin
            case (state)
                BYTE0: if (ack) byte_buf[7:0]   <= mem_rdata_i;
                BYTE1: if (ack) byte_buf[15:8]  <= mem_rdata_i;
                BYTE2: if (ack) byte_buf[23:16] <= mem_rdata_i;
                BYTE3: begin
                    if (ack) begin
                        if_inst_o  <= {mem_rdata_i, byte_buf};
                        if_pc_o    <= pc;
                        if_valid_o <= 1'b1;
                    end
                end
                HOLD: begin
                    // Bubble outputs go back to zero once the word is taken.
                    if (consume) begin
                        pc         <= pc + 32'd4;
                        if_pc_o    <= ZERO_WORD;
                        if_inst_o  <= ZERO_WORD;
                        if_valid_o <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
